reveal_cells: RTL and testbench
===============================

Name: reveal_cells

Overview:
- Downstream consumer of the mine placement stage in the minesweeper datapath.
- After mines and adjacency counts are written, this block handles one player click per start/ack handshake.
- It reads the mine board and the adjacency board through their shared read port and keeps the revealed-cell bitmap internally.
- On a click it reveals the cell, detects a mine hit, flood-reveals zero-adjacency regions by repeated raster sweeps, and reports the revealed count and win status.

Parameters:
boardWidth, 8, columns on the board
boardHeight, 8, rows on the board
coordWidth, 3, bits per X/Y coordinate (covers max(boardWidth, boardHeight) - 1)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  in INIT: begin processing the click at clickX/clickY
ack  input  1  in DONE: return to INIT
newGame  input  1  in INIT, with start low: clear revealed bitmap and count
clickX  input  coordWidth  clicked column, sampled on the start cycle
clickY  input  coordWidth  clicked row, sampled on the start cycle
totalMinesIn  input  7  mines on board, used for the win check
readX  output  coordWidth  board read column (combinational read)
readY  output  coordWidth  board read row
mineBoardReadValue  input  1  mine bit at (readX, readY), same cycle
adjBoardReadValue  input  4  adjacent-mine count at (readX, readY), same cycle
revealed  output  boardWidth*boardHeight  bit index y*boardWidth+x, 1 = revealed
revealedCount  output  7  number of revealed cells
hitMine  output  1  last click landed on a mine
win  output  1  all non-mine cells revealed
init, check, sweep, done  output  1 each  one-hot state indicators

Behaviour:
- Reset (async, active-high): state INIT; revealed, revealedCount, hitMine, win = 0; latched click = 0; scan index = 0.
- readX/readY:
  - INIT and CHECK: latched click coordinates.
  - SWEEP: scan coordinates (x = index mod boardWidth, y = index div boardWidth).
  - DONE: 0.
- INIT:
  - newGame=1 and start=0: clear revealed, revealedCount, hitMine and win.
  - start=1: latch clickX/clickY, clear hitMine, go to CHECK. start has priority over newGame when both are high.
- CHECK (1 cycle):
  - Cell already revealed: no change, go to DONE.
  - Mine: set the cell's revealed bit, set hitMine=1, do not increment the count, go to DONE.
  - Otherwise: set the bit and increment the count.
    - adj==0: go to SWEEP with index=0 and changed=0.
    - adj!=0: go to DONE.
- SWEEP (1 cell per cycle):
  - If the scanned cell is revealed, adj==0 and not a mine: set the revealed bits of all in-bounds 8-neighbours in the same cycle.
  - Neighbours are clipped at edges and corners; no wrap-around.
  - revealedCount increases by the number of newly set bits (0..8). Set changed if that number is >0.
  - At the last index (boardWidth*boardHeight-1):
    - If changed, including this cycle: index=0, changed=0, start another pass.
    - Otherwise go to DONE.
- DONE:
  - win = (revealedCount == boardWidth*boardHeight - totalMinesIn) and !hitMine, registered on DONE entry.
  - Outputs hold until ack=1, then go to INIT. revealed persists across clicks.
- start outside INIT and ack outside DONE are ignored. Reset mid-SWEEP aborts the sweep and clears everything.
- Latency:
  - Numbered cell: start -> DONE in 2 cycles.
  - Zero cell: 2 + N*(W*H) cycles for N passes; the final pass sees no change.

Test Plan:
- Mine at (3,3), click (3,3) -> DONE after 2 cycles; hitMine=1; revealed bit 27 only; revealedCount=0; win=0.
- Mine at (0,0), click (1,1) with adj=1 -> bit 9 set; revealedCount=1; no SWEEP entered; DONE 2 cycles after start.
- Single mine at (0,0), click (7,7) -> all 63 non-mine cells revealed; revealedCount=63; win=1; bit 0 clear.
- Mines along column 4 (8 mines), click (0,0):
  - Columns 0-3 revealed (32 cells, column 3 at adj>0); columns 5-7 unrevealed; revealedCount=32; win=0.
- Repeat the click on an already revealed cell -> revealedCount unchanged; DONE at cycle 2. Then newGame pulse -> revealed=0, count=0.
- Assert reset during SWEEP -> immediately INIT, revealed=0, outputs at reset values; a subsequent start works normally.

Source files
------------

// File: rtl/reveal_cells_if.sv
// -----------------------------------------------------------------------------
// reveal_cells_if
// Groups the click handshake, the board read port and the result outputs of
// the reveal_cells block into one bundle.
//   slave  modport : seen by reveal_cells (consumes clicks, drives results)
//   master modport : seen by the click source / board memory side
// Signals:
//   start, ack, newGame        handshake / game control
//   clickX, clickY             clicked cell, sampled with start
//   totalMinesIn               mines on board, for the win check
//   readX, readY               board read address (driven by reveal_cells)
//   mineBoardReadValue         mine bit at (readX, readY), same cycle
//   adjBoardReadValue          adjacent-mine count at (readX, readY), same cycle
//   revealed, revealedCount    revealed-cell bitmap (bit y*W+x) and its count
//   hitMine, win               click result flags
//   init, check, sweep, done   one-hot state indicators
// -----------------------------------------------------------------------------
interface reveal_cells_if #(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  parameter int coordWidth  = 3
);
  logic                              start;
  logic                              ack;
  logic                              newGame;
  logic [coordWidth-1:0]             clickX;
  logic [coordWidth-1:0]             clickY;
  logic [6:0]                        totalMinesIn;
  logic [coordWidth-1:0]             readX;
  logic [coordWidth-1:0]             readY;
  logic                              mineBoardReadValue;
  logic [3:0]                        adjBoardReadValue;
  logic [boardWidth*boardHeight-1:0] revealed;
  logic [6:0]                        revealedCount;
  logic                              hitMine;
  logic                              win;
  logic                              init;
  logic                              check;
  logic                              sweep;
  logic                              done;

  modport slave (
    input  start, ack, newGame, clickX, clickY, totalMinesIn,
    input  mineBoardReadValue, adjBoardReadValue,
    output readX, readY, revealed, revealedCount, hitMine, win,
    output init, check, sweep, done
  );

  modport master (
    output start, ack, newGame, clickX, clickY, totalMinesIn,
    output mineBoardReadValue, adjBoardReadValue,
    input  readX, readY, revealed, revealedCount, hitMine, win,
    input  init, check, sweep, done
  );
endinterface

// File: rtl/reveal_cells.sv
// -----------------------------------------------------------------------------
// reveal_cells
// Handles one minesweeper click per start/ack handshake. The clicked cell is
// revealed; a mine sets hitMine; a zero-adjacency cell triggers repeated raster
// sweeps that open all 8-neighbours of every revealed, non-mine, zero cell
// until a full pass adds nothing. The revealed bitmap lives here and persists
// across clicks until newGame or reset.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    reveal_cells_if.slave (handshake, board read port, results)
// -----------------------------------------------------------------------------
module reveal_cells #(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  parameter int coordWidth  = 3
) (
  input  logic          clk,
  input  logic          reset,
  reveal_cells_if.slave bus
);

  localparam int CELLS = boardWidth * boardHeight;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Registered state
  state_t                  state_r;
  logic [CELLS-1:0]        revealed_r;
  logic [6:0]              count_r;
  logic                    hit_r;
  logic                    win_r;
  logic [coordWidth-1:0]   click_x_r;
  logic [coordWidth-1:0]   click_y_r;
  logic [coordWidth-1:0]   scan_x_r;
  logic [coordWidth-1:0]   scan_y_r;
  logic                    changed_r;
  logic [3:0]              onehot_r;   // {done, sweep, check, init}

  // Next-state values
  state_t                  state_nx;
  logic [CELLS-1:0]        revealed_nx;
  logic [6:0]              count_nx;
  logic                    hit_nx;
  logic                    win_nx;
  logic [coordWidth-1:0]   click_x_nx;
  logic [coordWidth-1:0]   click_y_nx;
  logic [coordWidth-1:0]   scan_x_nx;
  logic [coordWidth-1:0]   scan_y_nx;
  logic                    changed_nx;
  logic [3:0]              onehot_nx;

  // Combinational helpers
  logic [coordWidth-1:0]   rd_x_s;
  logic [coordWidth-1:0]   rd_y_s;
  logic [IDX_W-1:0]        click_pos_s;
  logic [IDX_W-1:0]        scan_pos_s;
  logic                    expand_s;
  logic [CELLS-1:0]        nbr_mask_s;
  logic [3:0]              nbr_cnt_s;
  logic                    scan_last_s;
  logic                    changed_any_s;

  // Win means every non-mine cell is open and the click did not hit a mine.
  function automatic logic win_calc(input logic [6:0] cnt, input logic hit,
                                    input logic [6:0] mines);
    logic [6:0] need;
    need = 7'(CELLS) - mines;
    return (cnt == need) && !hit;
  endfunction

  assign click_pos_s = IDX_W'(int'(click_y_r) * boardWidth + int'(click_x_r));
  assign scan_pos_s  = IDX_W'(int'(scan_y_r) * boardWidth + int'(scan_x_r));
  assign scan_last_s = (scan_x_r == coordWidth'(boardWidth - 1)) &&
                       (scan_y_r == coordWidth'(boardHeight - 1));

  // Board read address: the click during INIT/CHECK, the scan cell in SWEEP.
  always_comb begin
    rd_x_s = {coordWidth{1'b0}};
    rd_y_s = {coordWidth{1'b0}};
    case (state_r)
      ST_INIT, ST_CHECK: begin
        rd_x_s = click_x_r;
        rd_y_s = click_y_r;
      end
      ST_SWEEP: begin
        rd_x_s = scan_x_r;
        rd_y_s = scan_y_r;
      end
      ST_DONE: begin
        rd_x_s = {coordWidth{1'b0}};
        rd_y_s = {coordWidth{1'b0}};
      end
      default: begin
        rd_x_s = {coordWidth{1'b0}};
        rd_y_s = {coordWidth{1'b0}};
      end
    endcase
  end

  // Scanned cell opens its neighbours only if it is revealed, safe and zero.
  assign expand_s = revealed_r[scan_pos_s] && !bus.mineBoardReadValue &&
                    (bus.adjBoardReadValue == 4'd0);

  // Not-yet-revealed in-bounds 8-neighbours of the scan cell, and how many.
  // Out-of-bounds neighbours point at index 0 but contribute a zero bit, so
  // edges and corners clip without wrapping.
  always_comb begin
    int               nx;
    int               ny;
    logic             in_b;
    logic [IDX_W-1:0] pos;
    logic             new_bit;
    nbr_mask_s = {CELLS{1'b0}};
    nbr_cnt_s  = 4'd0;
    nx         = 0;
    ny         = 0;
    in_b       = 1'b0;
    pos        = {IDX_W{1'b0}};
    new_bit    = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx      = int'(scan_x_r) + dx;
        ny      = int'(scan_y_r) + dy;
        in_b    = (nx >= 0) && (nx < boardWidth) && (ny >= 0) &&
                  (ny < boardHeight) && !((dx == 0) && (dy == 0));
        pos     = in_b ? IDX_W'(ny * boardWidth + nx) : {IDX_W{1'b0}};
        new_bit = in_b && !revealed_r[pos];
        nbr_mask_s[pos] = nbr_mask_s[pos] | new_bit;
        nbr_cnt_s       = nbr_cnt_s + {3'b000, new_bit};
      end
    end
  end

  // A pass counts as changed if any earlier cell or this one opened cells.
  assign changed_any_s = changed_r || (expand_s && (nbr_cnt_s != 4'd0));

  // Next-state and datapath update for the click FSM.
  always_comb begin
    state_nx    = state_r;
    revealed_nx = revealed_r;
    count_nx    = count_r;
    hit_nx      = hit_r;
    win_nx      = win_r;
    click_x_nx  = click_x_r;
    click_y_nx  = click_y_r;
    scan_x_nx   = scan_x_r;
    scan_y_nx   = scan_y_r;
    changed_nx  = changed_r;

    case (state_r)
      ST_INIT: begin
        if (bus.start) begin
          click_x_nx = bus.clickX;
          click_y_nx = bus.clickY;
          hit_nx     = 1'b0;
          state_nx   = ST_CHECK;
        end else if (bus.newGame) begin
          revealed_nx = {CELLS{1'b0}};
          count_nx    = 7'd0;
          hit_nx      = 1'b0;
          win_nx      = 1'b0;
        end else begin
          state_nx = ST_INIT;
        end
      end

      ST_CHECK: begin
        if (revealed_r[click_pos_s]) begin
          state_nx = ST_DONE;
          win_nx   = win_calc(count_r, hit_r, bus.totalMinesIn);
        end else if (bus.mineBoardReadValue) begin
          revealed_nx[click_pos_s] = 1'b1;
          hit_nx                   = 1'b1;
          state_nx                 = ST_DONE;
          win_nx                   = 1'b0;
        end else begin
          revealed_nx[click_pos_s] = 1'b1;
          count_nx                 = count_r + 7'd1;
          if (bus.adjBoardReadValue == 4'd0) begin
            state_nx   = ST_SWEEP;
            scan_x_nx  = {coordWidth{1'b0}};
            scan_y_nx  = {coordWidth{1'b0}};
            changed_nx = 1'b0;
          end else begin
            state_nx = ST_DONE;
            win_nx   = win_calc(count_r + 7'd1, hit_r, bus.totalMinesIn);
          end
        end
      end

      ST_SWEEP: begin
        if (expand_s) begin
          revealed_nx = revealed_r | nbr_mask_s;
          count_nx    = count_r + {3'b000, nbr_cnt_s};
        end else begin
          revealed_nx = revealed_r;
        end
        if (scan_last_s) begin
          scan_x_nx  = {coordWidth{1'b0}};
          scan_y_nx  = {coordWidth{1'b0}};
          changed_nx = 1'b0;
          if (changed_any_s) begin
            state_nx = ST_SWEEP;
          end else begin
            state_nx = ST_DONE;
            win_nx   = win_calc(count_nx, hit_r, bus.totalMinesIn);
          end
        end else begin
          changed_nx = changed_any_s;
          if (scan_x_r == coordWidth'(boardWidth - 1)) begin
            scan_x_nx = {coordWidth{1'b0}};
            scan_y_nx = scan_y_r + {{(coordWidth-1){1'b0}}, 1'b1};
          end else begin
            scan_x_nx = scan_x_r + {{(coordWidth-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_DONE: begin
        if (bus.ack) begin
          state_nx = ST_INIT;
        end else begin
          state_nx = ST_DONE;
        end
      end

      default: begin
        state_nx = ST_INIT;
      end
    endcase
  end

  // One-hot state indicators, registered alongside the state.
  always_comb begin
    onehot_nx = 4'b0001;
    case (state_nx)
      ST_INIT:  onehot_nx = 4'b0001;
      ST_CHECK: onehot_nx = 4'b0010;
      ST_SWEEP: onehot_nx = 4'b0100;
      ST_DONE:  onehot_nx = 4'b1000;
      default:  onehot_nx = 4'b0001;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      revealed_r <= {CELLS{1'b0}};
      count_r    <= 7'd0;
      hit_r      <= 1'b0;
      win_r      <= 1'b0;
      click_x_r  <= {coordWidth{1'b0}};
      click_y_r  <= {coordWidth{1'b0}};
      scan_x_r   <= {coordWidth{1'b0}};
      scan_y_r   <= {coordWidth{1'b0}};
      changed_r  <= 1'b0;
      onehot_r   <= 4'b0001;
    end else begin
      state_r    <= state_nx;
      revealed_r <= revealed_nx;
      count_r    <= count_nx;
      hit_r      <= hit_nx;
      win_r      <= win_nx;
      click_x_r  <= click_x_nx;
      click_y_r  <= click_y_nx;
      scan_x_r   <= scan_x_nx;
      scan_y_r   <= scan_y_nx;
      changed_r  <= changed_nx;
      onehot_r   <= onehot_nx;
    end
  end

  assign bus.readX         = rd_x_s;
  assign bus.readY         = rd_y_s;
  assign bus.revealed      = revealed_r;
  assign bus.revealedCount = count_r;
  assign bus.hitMine       = hit_r;
  assign bus.win           = win_r;
  assign bus.init          = onehot_r[0];
  assign bus.check         = onehot_r[1];
  assign bus.sweep         = onehot_r[2];
  assign bus.done          = onehot_r[3];

endmodule

// File: tb/tb_reveal_cells.sv
// -----------------------------------------------------------------------------
// tb_reveal_cells
// Directed bench for reveal_cells. The bench models the mine board and its
// adjacency counts behind the read port; expected click results are queued
// when a click is issued and checked when the block reaches DONE.
// -----------------------------------------------------------------------------
module tb_reveal_cells;

  typedef struct {
    logic [63:0] rev;
    logic [6:0]  cnt;
    logic        hit;
    logic        win;
    int          lat;   // expected start->DONE cycles, -1 = not checked
  } exp_t;

  logic        clk;
  logic        reset;
  logic [63:0] mines;
  exp_t        sb_q[$];
  int          total;
  int          bad;

  reveal_cells_if #(.boardWidth(8), .boardHeight(8), .coordWidth(3)) bus ();

  reveal_cells #(.boardWidth(8), .boardHeight(8), .coordWidth(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of mines among the in-bounds neighbours of (x, y).
  function automatic logic [3:0] adj_of(input logic [63:0] m, input int x, input int y);
    logic [3:0] c;
    int         nx;
    int         ny;
    c = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = x + dx;
        ny = y + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
          if (m[ny*8+nx]) c = c + 4'd1;
        end
      end
    end
    return c;
  endfunction

  // Board memory model: same-cycle read at (readX, readY).
  always_comb begin
    bus.mineBoardReadValue = mines[{bus.readY, bus.readX}];
    bus.adjBoardReadValue  = adj_of(mines, int'(bus.readX), int'(bus.readY));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_game();
    bus.newGame = 1'b1;
    @(posedge clk);
    #1 bus.newGame = 1'b0;
    chk("newgame_revealed", bus.revealed, 64'd0);
    chk("newgame_count", {57'd0, bus.revealedCount}, 64'd0);
    chk("newgame_init", {63'd0, bus.init}, 64'd1);
  endtask

  task automatic do_click(input string tag, input logic [2:0] x, input logic [2:0] y,
                          input exp_t e);
    exp_t got;
    int   n;
    sb_q.push_back(e);
    bus.clickX = x;
    bus.clickY = y;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_done_reached"}, {63'd0, bus.done}, 64'd1);
    got = sb_q.pop_front();
    chk({tag, "_revealed"}, bus.revealed, got.rev);
    chk({tag, "_count"}, {57'd0, bus.revealedCount}, {57'd0, got.cnt});
    chk({tag, "_hit"}, {63'd0, bus.hitMine}, {63'd0, got.hit});
    chk({tag, "_win"}, {63'd0, bus.win}, {63'd0, got.win});
    chk({tag, "_read_zero_in_done"}, {58'd0, bus.readY, bus.readX}, 64'd0);
    if (got.lat >= 0) chk({tag, "_latency"}, 64'(n), 64'(got.lat));
    // start while in DONE must be ignored
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, "_hold_done"}, {63'd0, bus.done}, 64'd1);
    bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
    chk({tag, "_back_init"}, {63'd0, bus.init}, 64'd1);
  endtask

  initial begin
    int n;
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    mines            = 64'd0;
    bus.start        = 1'b0;
    bus.ack          = 1'b0;
    bus.newGame      = 1'b0;
    bus.clickX       = 3'd0;
    bus.clickY       = 3'd0;
    bus.totalMinesIn = 7'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_init", {60'd0, bus.done, bus.sweep, bus.check, bus.init}, 64'd1);
    chk("rst_revealed", bus.revealed, 64'd0);
    chk("rst_count", {57'd0, bus.revealedCount}, 64'd0);
    chk("rst_flags", {62'd0, bus.hitMine, bus.win}, 64'd0);

    // Click on a mine
    mines            = 64'd1 << 27;
    bus.totalMinesIn = 7'd1;
    do_click("mine", 3'd3, 3'd3, '{rev: 64'd1 << 27, cnt: 7'd0, hit: 1'b1, win: 1'b0, lat: 2});

    // Numbered cell next to a corner mine
    new_game();
    mines = 64'd1;
    do_click("numbered", 3'd1, 3'd1, '{rev: 64'd1 << 9, cnt: 7'd1, hit: 1'b0, win: 1'b0, lat: 2});

    // Flood from the far corner opens every safe cell
    do_click("flood_win", 3'd7, 3'd7, '{rev: ~64'd1, cnt: 7'd63, hit: 1'b0, win: 1'b1, lat: -1});

    // Wall of mines in column 4 stops the flood at column 3
    new_game();
    mines            = 64'h1010_1010_1010_1010;
    bus.totalMinesIn = 7'd8;
    do_click("wall", 3'd0, 3'd0, '{rev: 64'h0F0F_0F0F_0F0F_0F0F, cnt: 7'd32, hit: 1'b0, win: 1'b0, lat: -1});

    // Clicking an already revealed cell changes nothing
    do_click("repeat", 3'd0, 3'd0, '{rev: 64'h0F0F_0F0F_0F0F_0F0F, cnt: 7'd32, hit: 1'b0, win: 1'b0, lat: 2});
    new_game();

    // Reset in the middle of a sweep
    bus.clickX = 3'd0;
    bus.clickY = 3'd0;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (!bus.sweep && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("abort_in_sweep", {63'd0, bus.sweep}, 64'd1);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_init", {60'd0, bus.done, bus.sweep, bus.check, bus.init}, 64'd1);
    chk("abort_revealed", bus.revealed, 64'd0);
    chk("abort_count", {57'd0, bus.revealedCount}, 64'd0);
    chk("abort_flags", {62'd0, bus.hitMine, bus.win}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Normal click after the abort: (3,3) touches three wall mines
    do_click("after_abort", 3'd3, 3'd3, '{rev: 64'd1 << 27, cnt: 7'd1, hit: 1'b0, win: 1'b0, lat: 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
